// File: rtl/div_unit.sv
// rtl/div_unit.sv - iterative radix-2 restoring divider for DIV/DIVU (HI/LO result)
module div_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        div_valid,
  input  logic        div_sign,
  input  logic [31:0] opdata1,
  input  logic [31:0] opdata2,
  input  logic        annul,
  output logic        busy,
  output logic        ready,
  output logic [63:0] result
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ON   = 2'd1,
    S_END  = 2'd2
  } state_t;

  state_t      r_state;
  logic [4:0]  r_cnt;
  logic        r_neg_quo;
  logic        r_neg_rem;
  logic [31:0] r_divisor;
  logic [63:0] r_work;
  logic        r_ready;
  logic [63:0] r_result;

  logic [31:0] w_abs1;
  logic [31:0] w_abs2;
  logic [64:0] w_shifted;
  logic        w_ge;
  logic [31:0] w_diff;
  logic [63:0] w_next;
  logic [31:0] w_quo;
  logic [31:0] w_rem;
  logic [31:0] w_fix_quo;
  logic [31:0] w_fix_rem;

  // Magnitudes of the operands; only signed requests with bit31 set are negated
  assign w_abs1 = (div_sign && opdata1[31]) ? (~opdata1 + 32'd1) : opdata1;
  assign w_abs2 = (div_sign && opdata2[31]) ? (~opdata2 + 32'd1) : opdata2;

  // One restoring step: shift the {rem, quo} pair left, then trial-subtract the
  // divisor from the upper 33 bits. When the difference is non-negative it is
  // strictly below the divisor, so it always fits back into 32 bits.
  assign w_shifted = {r_work, 1'b0};
  assign w_ge      = (w_shifted[64:32] >= {1'b0, r_divisor});
  assign w_diff    = w_shifted[63:32] - r_divisor;
  assign w_next    = w_ge ? {w_diff, w_shifted[31:1], 1'b1} : w_shifted[63:0];

  assign w_quo     = w_next[31:0];
  assign w_rem     = w_next[63:32];
  assign w_fix_quo = r_neg_quo ? (~w_quo + 32'd1) : w_quo;
  assign w_fix_rem = r_neg_rem ? (~w_rem + 32'd1) : w_rem;

  // Stall request: asserted for an accepted request and for the whole iteration phase
  assign busy = ((r_state == S_IDLE) && div_valid && !annul) || (r_state == S_ON);

  assign ready  = r_ready;
  assign result = r_result;

  // Control FSM with datapath; ready and result are registered on entry to END
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= 5'd0;
      r_neg_quo <= 1'b0;
      r_neg_rem <= 1'b0;
      r_divisor <= 32'd0;
      r_work    <= 64'd0;
      r_ready   <= 1'b0;
      r_result  <= 64'd0;
    end else begin
      r_ready <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (div_valid && !annul) begin
            r_neg_quo <= div_sign && (opdata1[31] ^ opdata2[31]);
            r_neg_rem <= div_sign && opdata1[31];
            r_divisor <= w_abs2;
            r_cnt     <= 5'd0;
            if (opdata2 == 32'd0) begin
              r_state  <= S_END;
              r_ready  <= 1'b1;
              r_result <= 64'd0;
            end else begin
              r_work  <= {32'd0, w_abs1};
              r_state <= S_ON;
            end
          end
        end
        S_ON: begin
          if (annul) begin
            r_state <= S_IDLE;
            r_cnt   <= 5'd0;
          end else begin
            r_work <= w_next;
            r_cnt  <= r_cnt + 5'd1;
            if (r_cnt == 5'd31) begin
              r_state  <= S_END;
              r_ready  <= 1'b1;
              r_result <= {w_fix_rem, w_fix_quo};
            end
          end
        end
        S_END: begin
          r_state <= S_IDLE;
          r_cnt   <= 5'd0;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - self-checking bench for div_unit
module tb_div_unit;

  logic        clk;
  logic        rst;
  logic        div_valid;
  logic        div_sign;
  logic [31:0] opdata1;
  logic [31:0] opdata2;
  logic        annul;
  logic        busy;
  logic        ready;
  logic [63:0] result;

  int n_checks;
  int n_errors;

  logic [63:0] exp_q[$];
  logic [63:0] last_exp;

  div_unit dut (
    .clk       (clk),
    .rst       (rst),
    .div_valid (div_valid),
    .div_sign  (div_sign),
    .opdata1   (opdata1),
    .opdata2   (opdata2),
    .annul     (annul),
    .busy      (busy),
    .ready     (ready),
    .result    (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        s;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic s, input logic [31:0] a, input logic [31:0] b);
    int sa;
    int sb;
    logic [31:0] q;
    logic [31:0] r;
    if (b == 32'd0) return 64'd0;
    if (s) begin
      if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
      sa = a;
      sb = b;
      q  = sa / sb;
      r  = sa % sb;
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  // Scoreboard: every ready pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (!rst && ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_ready actual=%h expected=no_pulse", result);
      end else begin
        chk("result", result, exp_q.pop_front());
      end
    end
  end

  task automatic do_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp, input string nm);
    int lat;
    int bcnt;
    int exp_lat;
    logic seen;
    exp_lat = (b == 32'd0) ? 1 : 33;
    @(negedge clk);
    div_sign  = s;
    opdata1   = a;
    opdata2   = b;
    div_valid = 1'b1;
    exp_q.push_back(exp);
    last_exp = exp;
    #1 bcnt = busy ? 1 : 0;
    @(posedge clk);
    #1 div_valid = 1'b0;
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 40) begin
      @(negedge clk);
      lat++;
      if (ready) seen = 1'b1;
      else if (busy) bcnt++;
    end
    if (!seen) void'(exp_q.pop_front());
    chk({nm, "_latency"}, 64'(lat), 64'(exp_lat));
    chk({nm, "_busy_cycles"}, 64'(bcnt), 64'(exp_lat));
  endtask

  initial begin
    int rdy;
    logic        rs;
    logic [31:0] ra;
    logic [31:0] rb;

    n_checks  = 0;
    n_errors  = 0;
    last_exp  = 64'd0;
    rst       = 1'b1;
    div_valid = 1'b0;
    div_sign  = 1'b0;
    opdata1   = 32'd0;
    opdata2   = 32'd0;
    annul     = 1'b0;

    tbl[0]  = '{1'b0, 32'd100,        32'd7,          {32'd2,        32'd14}};
    tbl[1]  = '{1'b1, 32'hFFFFFFF9,   32'd2,          {32'hFFFFFFFF, 32'hFFFFFFFD}};
    tbl[2]  = '{1'b0, 32'hFFFFFFF9,   32'd2,          {32'h1,        32'h7FFFFFFC}};
    tbl[3]  = '{1'b1, 32'h80000000,   32'hFFFFFFFF,   {32'h0,        32'h80000000}};
    tbl[4]  = '{1'b1, 32'd7,          32'hFFFFFFFE,   {32'h1,        32'hFFFFFFFD}};
    tbl[5]  = '{1'b0, 32'd123,        32'd0,          64'd0};
    tbl[6]  = '{1'b1, 32'hFFFFFF9C,   32'd0,          64'd0};
    tbl[7]  = '{1'b0, 32'hFFFFFFFF,   32'd1,          {32'h0,        32'hFFFFFFFF}};
    tbl[8]  = '{1'b0, 32'd5,          32'd9,          {32'd5,        32'd0}};
    tbl[9]  = '{1'b1, 32'hFFFFFFF9,   32'hFFFFFFFE,   {32'hFFFFFFFF, 32'd3}};
    tbl[10] = '{1'b0, 32'hFFFFFFFF,   32'hFFFFFFFF,   {32'h0,        32'h1}};
    tbl[11] = '{1'b1, 32'h7FFFFFFF,   32'h10,         {32'hF,        32'h07FFFFFF}};

    repeat (2) @(posedge clk);
    #1;
    chk("reset_ready", 64'(ready), 64'd0);
    chk("reset_result", result, 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 12; i++)
      do_div(tbl[i].s, tbl[i].a, tbl[i].b, tbl[i].exp, $sformatf("vec%0d", i));

    for (int i = 0; i < 8; i++) begin
      rs = 1'($urandom_range(0, 1));
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 31);
      do_div(rs, ra, rb, model(rs, ra, rb), $sformatf("rnd%0d", i));
    end

    // annul during iteration 10 of 50 / 5
    @(negedge clk);
    div_sign  = 1'b0;
    opdata1   = 32'd50;
    opdata2   = 32'd5;
    div_valid = 1'b1;
    @(posedge clk);
    #1 div_valid = 1'b0;
    repeat (10) @(negedge clk);
    annul = 1'b1;
    @(posedge clk);
    #1 annul = 1'b0;
    chk("annul_busy", 64'(busy), 64'd0);
    chk("annul_result_kept", result, last_exp);
    rdy = 0;
    repeat (40) begin
      @(negedge clk);
      if (ready) rdy++;
    end
    chk("annul_no_ready", 64'(rdy), 64'd0);
    do_div(1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, "after_annul");

    // annul in IDLE drops the request
    @(negedge clk);
    opdata1   = 32'd8;
    opdata2   = 32'd2;
    div_valid = 1'b1;
    annul     = 1'b1;
    #1 chk("idle_annul_busy", 64'(busy), 64'd0);
    @(posedge clk);
    #1;
    div_valid = 1'b0;
    annul     = 1'b0;
    chk("idle_annul_state_busy", 64'(busy), 64'd0);
    rdy = 0;
    repeat (5) begin
      @(negedge clk);
      if (ready) rdy++;
    end
    chk("idle_annul_no_ready", 64'(rdy), 64'd0);

    // reset at iteration 20
    @(negedge clk);
    opdata1   = 32'd100;
    opdata2   = 32'd7;
    div_valid = 1'b1;
    @(posedge clk);
    #1 div_valid = 1'b0;
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_ready", 64'(ready), 64'd0);
    chk("rst_result", result, 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    @(negedge clk);
    do_div(1'b0, 32'd1000, 32'd10, {32'd0, 32'd100}, "after_rst");

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
